// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the core load/store path and an external port.
// Define DMEM_ARB_STARVE_GUARD_EN to build the external-port starvation guard (forced grant + core stall).
`ifndef DATA_DEPTH
`define DATA_DEPTH 1024
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif

module dmem_arbiter #(
    parameter int ADDR_W       = $clog2(`DATA_DEPTH),
    parameter int DATA_W       = `REG_WIDTH,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_en,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_stall,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_EXT  = 2'd2
    } owner_t;

    owner_t rd_owner;
    owner_t rd_owner_nxt;
    logic   core_gnt;
    logic   force_ext;

    if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
        $error("dmem_arbiter: STARVE_LIMIT must be at least 1");
    end

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;

    // A full count means the external port has waited long enough to pre-empt the core.
    assign force_ext = ext_req && (starve_cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst || ext_gnt) begin
            starve_cnt <= '0;
        end else if (ext_req && (starve_cnt != CNT_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign force_ext = 1'b0;
`endif

    // Stage 0: combinational grant and RAM mux, all forced idle during reset.
    always_comb begin
        core_gnt   = 1'b0;
        ext_gnt    = 1'b0;
        core_stall = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_din    = '0;
        if (!rst) begin
            if (core_en && !force_ext) begin
                core_gnt = 1'b1;
            end else if (ext_req) begin
                ext_gnt    = 1'b1;
                core_stall = core_en;
            end
            if (core_gnt) begin
                mem_en   = 1'b1;
                mem_we   = core_we;
                mem_addr = core_addr;
                mem_din  = core_wdata;
            end else if (ext_gnt) begin
                mem_en   = 1'b1;
                mem_we   = ext_we;
                mem_addr = ext_addr;
                mem_din  = ext_wdata;
            end
        end
    end

    always_comb begin
        rd_owner_nxt = OWN_NONE;
        if (core_gnt && !core_we) begin
            rd_owner_nxt = OWN_CORE;
        end else if (ext_gnt && !ext_we) begin
            rd_owner_nxt = OWN_EXT;
        end
    end

    // Stage 1: owner tag lines up with the RAM's one-cycle read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_owner <= OWN_NONE;
        end else begin
            rd_owner <= rd_owner_nxt;
        end
    end

    assign core_rvalid = (rd_owner == OWN_CORE);
    assign ext_rvalid  = (rd_owner == OWN_EXT);
    assign core_rdata  = mem_dout;
    assign ext_rdata   = mem_dout;

    a_single_owner: assert property (@(posedge clk) disable iff (rst) !(ext_gnt && core_gnt));

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the single-port data RAM in the memory stage between the core load/store path and an external port (debug / loader / DMA). Core accesses normally win. The external port uses a req/gnt handshake. Read responses come back one cycle after grant, matching the RAM's 1-cycle read latency, and are routed by a registered owner tag. An optional starvation guard forces an external grant, with a one-cycle core stall, after a bounded wait.

## Interface
Parameters:
- ADDR_W, default $clog2(`DATA_DEPTH): word address width.
- DATA_W, default `REG_WIDTH (32): data width.
- STARVE_LIMIT, default 8: number of consecutive denied external cycles before a forced grant (guard builds only).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- core_en  in  1  core access request (load or store) this cycle.
- core_we  in  1  core store when 1.
- core_addr  in  ADDR_W  core word address.
- core_wdata  in  DATA_W  core store data (rs2).
- core_stall  out  1  core access not taken this cycle; the core must hold its request.
- core_rvalid  out  1  core read data valid.
- core_rdata  out  DATA_W  core read data.
- ext_req  in  1  external request; held with we/addr/wdata stable until ext_gnt.
- ext_we  in  1  external write when 1.
- ext_addr  in  ADDR_W  external word address.
- ext_wdata  in  DATA_W  external write data.
- ext_gnt  out  1  external access issued to RAM this cycle.
- ext_rvalid  out  1  external read data valid.
- ext_rdata  out  DATA_W  external read data.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_din  out  DATA_W  RAM write data.
- mem_dout  in  DATA_W  RAM read data (valid 1 cycle after a read issue).

## Operation
- Grant logic is combinational in the current cycle. While rst=1: mem_en=0, mem_we=0, ext_gnt=0, core_stall=0.
- Without a forced external grant: core_en=1 grants the core; otherwise ext_req=1 grants the external port; otherwise the RAM is idle (mem_en=0).
- Forced external grant (guard only): when both request, the external port wins, ext_gnt=1 and core_stall=1.
- The mux drives mem_en/we/addr/din from the granted requester. mem_addr and mem_din are 0 when idle.
- Owner register rd_owner ∈ {NONE, CORE, EXT}:
  - Set on each clock edge to the requester granted a read (we=0); NONE for writes or idle.
  - Reset value NONE.
- core_rvalid = (rd_owner==CORE); ext_rvalid = (rd_owner==EXT). Both rdata outputs carry mem_dout unconditionally; consumers qualify with rvalid.
- Writes produce no response.
- Back-to-back reads from either port are allowed every cycle. Each response appears exactly one cycle after its grant.
- Same address written and read in consecutive cycles returns the RAM's behaviour (new data); the arbiter adds no bypass.

## Timing
- Grant latency: 0 cycles, same cycle as the request.
- Read latency: 1 cycle from grant to rvalid.
- Reset values of registered outputs: core_rvalid=0, ext_rvalid=0, starvation counter=0.
- Reset asserted in the cycle after a read grant: rvalid is 0 in the following cycle, because rd_owner is cleared, and the response is dropped.
- An external requester must not deassert ext_req before ext_gnt. Behaviour on withdrawal is undefined, but must not corrupt rd_owner.
- ext_gnt and core access are never both active in one cycle. This invariant must be asserted.

## Configuration
- Macro: DMEM_ARB_STARVE_GUARD_EN.
- Defined:
  - A counter of width $clog2(STARVE_LIMIT+1) increments on every cycle with ext_req=1 and ext_gnt=0.
  - The counter clears on ext_gnt or rst.
  - When the counter equals STARVE_LIMIT, the external port gets the next grant even if core_en=1, with core_stall=1 in that cycle.
  - The core's request is served the following cycle.
- Undefined: no counter is built, core_stall is tied to 0, and the core always has priority.

## Test plan
- Reset: hold rst for 2 cycles with core_en=1 and ext_req=1 → mem_en=0, ext_gnt=0, core_rvalid=0 and ext_rvalid=0 in both cycles and in the cycle after.
- Core store then load: store addr 5 data 0xDEADBEEF, then load addr 5 → the load gets mem_en=1, mem_we=0; the next cycle gives core_rvalid=1 and core_rdata=0xDEADBEEF; ext_rvalid=0 throughout.
- External read while core idle: write 0x12345678 at addr 9, then ext_req read addr 9 → ext_gnt=1 in the same cycle; the next cycle gives ext_rvalid=1 and ext_rdata=0x12345678.
- Contention without the guard: core_en=1 for 20 cycles with ext_req held → ext_gnt=0 for all 20 cycles; ext_gnt=1 on the first cycle core_en=0.
- Contention with the guard (STARVE_LIMIT=8): core_en and ext_req held → ext_gnt=1 and core_stall=1 on cycle 9; the counter returns to 0; the core is granted on cycle 10.
- Interleaved reads: core read addr 1 in cycle t, external read addr 2 in cycle t+1 → core_rvalid in t+1 and ext_rvalid in t+2, each with the correct word and never both asserted.
